// File: rtl/gmii_udp_rx.sv
// GMII receiver for UDP/IPv4 frames: filters headers and packs the payload into 32-bit RAM words.
// Optional IPv4 header checksum verification is enabled by defining GMII_UDP_RX_CSUM_EN.
module gmii_udp_rx #(
   parameter logic [47:0] LOCAL_MAC  = 48'h000A3501FEC0,
   parameter logic [31:0] LOCAL_IP   = 32'hC0A80002,
   parameter logic [15:0] LOCAL_PORT = 16'h1F90,
   parameter logic [8:0]  RAM_BASE   = 9'd1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rxdv,
   input  logic        rxer,
   input  logic [7:0]  datain,
   output logic        ram_wr_en,
   output logic [8:0]  ram_wr_addr,
   output logic [31:0] ram_wr_data,
   output logic [3:0]  rx_state,
   output logic [15:0] rx_total_length,
   output logic [15:0] rx_data_length,
   output logic        rx_done,
   output logic        rx_err,
   output logic [31:0] rx_counter
);

   typedef enum logic [3:0] {
      IDLE = 4'd0, PREAMBLE = 4'd1, MAC = 4'd2, IPHDR = 4'd3,
      UDPHDR = 4'd4, DATA = 4'd5, DROP = 4'd6
   } state_t;

   localparam logic [5:0][7:0] MAC_B = LOCAL_MAC;
   localparam logic [3:0][7:0] IP_B  = LOCAL_IP;

   state_t      state, nstate;
   logic [15:0] cnt, ip_total, udp_len;
   logic        mac_nl, mac_nb, hdr_bad;
   logic        nl_now, nb_now, cur_bad, last, err_now, csum_bad;
   logic [23:0] wbuf;
   logic [1:0]  bidx;
   logic [8:0]  addr;
   logic [31:0] packed_w;

   assign rx_state = state;

`ifdef GMII_UDP_RX_CSUM_EN
   logic [31:0] csum, csum_s;
   logic [16:0] csum_f1;
   logic [15:0] csum_f2;
   logic [7:0]  hi;
   assign csum_s   = csum + {16'd0, hi, datain};
   assign csum_f1  = {1'b0, csum_s[15:0]} + {1'b0, csum_s[31:16]};
   assign csum_f2  = csum_f1[15:0] + {15'd0, csum_f1[16]};
   assign csum_bad = (state == IPHDR) && (cnt == 16'd19) && (csum_f2 != 16'hFFFF);
`else
   assign csum_bad = 1'b0;
`endif

   // Left-justify the bytes collected so far; stale high bits of wbuf shift out.
   assign packed_w = {wbuf, datain} << (5'd8 * 5'(2'd3 - bidx));

   always_comb begin
      nl_now  = 1'b0;
      nb_now  = 1'b0;
      cur_bad = 1'b0;
      last    = 1'b0;
      case (state)
         MAC: begin
            nl_now  = (cnt < 16'd6) && (datain != MAC_B[3'(3'd5 - cnt[2:0])]);
            nb_now  = (cnt < 16'd6) && (datain != 8'hFF);
            cur_bad = ((cnt == 16'd12) && (datain != 8'h08)) ||
                      ((cnt == 16'd13) && (datain != 8'h00));
         end
         IPHDR:
            cur_bad = ((cnt == 16'd0) && (datain != 8'h45)) ||
                      ((cnt == 16'd9) && (datain != 8'h11)) ||
                      ((cnt >= 16'd16) && (datain != IP_B[~cnt[1:0]]));
         UDPHDR:
            cur_bad = ((cnt == 16'd2) && (datain != LOCAL_PORT[15:8])) ||
                      ((cnt == 16'd3) && (datain != LOCAL_PORT[7:0]));
         DATA: last = (cnt == udp_len - 16'd9);
         default: ;
      endcase
   end

   always_comb begin
      nstate  = state;
      err_now = 1'b0;
      case (state)
         IDLE: if (rxdv && datain == 8'h55) nstate = PREAMBLE;
         DROP: if (!rxdv) nstate = IDLE;
         default: begin
            if (!rxdv) begin
               nstate  = IDLE;
               err_now = 1'b1;
            end else if (rxer) begin
               nstate  = DROP;
               err_now = 1'b1;
            end else begin
               case (state)
                  PREAMBLE:
                     if (datain == 8'hD5) nstate = MAC;
                     else if (datain != 8'h55) nstate = DROP;
                  MAC:
                     if (cnt == 16'd13)
                        nstate = (hdr_bad || cur_bad || (mac_nl && mac_nb)) ? DROP : IPHDR;
                  IPHDR:
                     if (cnt == 16'd19) begin
                        if (csum_bad) begin
                           nstate  = DROP;
                           err_now = 1'b1;
                        end else
                           nstate = (hdr_bad || cur_bad) ? DROP : UDPHDR;
                     end
                  UDPHDR:
                     if (cnt == 16'd7)
                        nstate = (hdr_bad || udp_len < 16'd9) ? DROP : DATA;
                  DATA: if (last) nstate = DROP;
                  default: nstate = IDLE;
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nstate;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0; ip_total <= '0; udp_len <= '0;
         mac_nl <= 1'b0; mac_nb <= 1'b0; hdr_bad <= 1'b0;
         wbuf <= '0; bidx <= '0; addr <= RAM_BASE;
         ram_wr_en <= 1'b0; ram_wr_addr <= '0; ram_wr_data <= '0;
         rx_total_length <= '0; rx_data_length <= '0;
         rx_done <= 1'b0; rx_err <= 1'b0; rx_counter <= '0;
`ifdef GMII_UDP_RX_CSUM_EN
         csum <= '0; hi <= '0;
`endif
      end else begin
         ram_wr_en <= 1'b0;
         rx_done   <= 1'b0;
         rx_err    <= err_now;
         if (nstate != state) cnt <= '0;
         else if (rxdv)       cnt <= cnt + 16'd1;

         if (state == PREAMBLE) begin
            mac_nl <= 1'b0; mac_nb <= 1'b0; hdr_bad <= 1'b0;
`ifdef GMII_UDP_RX_CSUM_EN
            csum <= '0;
`endif
         end else if (rxdv && (state == MAC || state == IPHDR || state == UDPHDR)) begin
            hdr_bad <= hdr_bad | cur_bad;
            mac_nl  <= mac_nl | nl_now;
            mac_nb  <= mac_nb | nb_now;
         end

         if (rxdv && state == IPHDR) begin
            if (cnt == 16'd2) ip_total[15:8] <= datain;
            if (cnt == 16'd3) ip_total[7:0]  <= datain;
`ifdef GMII_UDP_RX_CSUM_EN
            hi <= datain;
            if (cnt[0]) csum <= csum_s;
`endif
         end

         if (rxdv && state == UDPHDR) begin
            if (cnt == 16'd4) udp_len[15:8] <= datain;
            if (cnt == 16'd5) udp_len[7:0]  <= datain;
            bidx <= '0;
            addr <= RAM_BASE;
         end

         if (rxdv && !rxer && state == DATA) begin
            wbuf <= {wbuf[15:0], datain};
            if (bidx == 2'd3 || last) begin
               ram_wr_en   <= 1'b1;
               ram_wr_addr <= addr;
               ram_wr_data <= packed_w;
               addr        <= addr + 9'd1;
               bidx        <= '0;
            end else
               bidx <= bidx + 2'd1;
            if (last) begin
               rx_done         <= 1'b1;
               rx_data_length  <= udp_len;
               rx_total_length <= ip_total;
               rx_counter      <= rx_counter + 32'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_gmii_udp_rx.sv
// Directed bench for gmii_udp_rx: builds frames byte by byte and checks RAM writes and status.
module tb_gmii_udp_rx;
   logic        clk = 1'b0, rst = 1'b1, rxdv = 1'b0, rxer = 1'b0;
   logic [7:0]  datain = 8'h00;
   logic        ram_wr_en, rx_done, rx_err;
   logic [8:0]  ram_wr_addr;
   logic [31:0] ram_wr_data, rx_counter;
   logic [3:0]  rx_state;
   logic [15:0] rx_total_length, rx_data_length;

   gmii_udp_rx dut (
      .clk(clk), .rst(rst), .rxdv(rxdv), .rxer(rxer), .datain(datain),
      .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
      .rx_state(rx_state), .rx_total_length(rx_total_length),
      .rx_data_length(rx_data_length), .rx_done(rx_done), .rx_err(rx_err),
      .rx_counter(rx_counter)
   );

   always #5 clk = ~clk;

   int checks = 0, fails = 0;
   int nwr = 0, ndone = 0, nerr = 0, done_alone = 0;
   logic [8:0]  wa[$];
   logic [31:0] wd[$];
   logic [7:0]  fr[$];

   always @(negedge clk) begin
      if (ram_wr_en) begin
         wa.push_back(ram_wr_addr);
         wd.push_back(ram_wr_data);
         nwr++;
      end
      if (rx_done) ndone++;
      if (rx_done && !ram_wr_en) done_alone++;
      if (rx_err) nerr++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic dv, input logic er, input logic [7:0] d);
      @(posedge clk);
      #1;
      rxdv = dv; rxer = er; datain = d;
   endtask

   task automatic build(input logic [47:0] dmac, input logic [15:0] port, input int n,
                        input logic [7:0] first, input logic [7:0] step, input logic [15:0] cdelta);
      logic [15:0] tl, ul, ck;
      logic [31:0] s;
      logic [7:0]  ip[20];
      fr.delete();
      ul = 16'(n + 8);
      tl = ul + 16'd20;
      for (int i = 0; i < 6; i++) fr.push_back(dmac[8*(5-i) +: 8]);
      fr.push_back(8'h02); fr.push_back(8'h00); fr.push_back(8'h00);
      fr.push_back(8'h00); fr.push_back(8'h00); fr.push_back(8'h01);
      fr.push_back(8'h08); fr.push_back(8'h00);
      ip = '{8'h45, 8'h00, tl[15:8], tl[7:0], 8'h12, 8'h34, 8'h40, 8'h00, 8'h40, 8'h11,
             8'h00, 8'h00, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'h02};
      s = 32'd0;
      for (int i = 0; i < 20; i += 2) s += {16'd0, ip[i], ip[i+1]};
      s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
      s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
      ck = ~s[15:0] + cdelta;
      ip[10] = ck[15:8]; ip[11] = ck[7:0];
      for (int i = 0; i < 20; i++) fr.push_back(ip[i]);
      fr.push_back(8'h13); fr.push_back(8'h88);
      fr.push_back(port[15:8]); fr.push_back(port[7:0]);
      fr.push_back(ul[15:8]); fr.push_back(ul[7:0]);
      fr.push_back(8'h00); fr.push_back(8'h00);
      for (int i = 0; i < n; i++) fr.push_back(first + 8'(i) * step);
   endtask

   // cut: number of frame bytes sent before rxdv falls (-1 = whole frame + FCS)
   task automatic send(input int cut, input int er_at);
      repeat (7) drive(1'b1, 1'b0, 8'h55);
      drive(1'b1, 1'b0, 8'hD5);
      for (int i = 0; i < fr.size(); i++) begin
         if (i == cut) break;
         drive(1'b1, i == er_at, fr[i]);
      end
      if (cut < 0) for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'hC3);
      repeat (6) drive(1'b0, 1'b0, 8'h00);
   endtask

   localparam logic [47:0] GOOD = 48'h000A3501FEC0;
   int w0, d0, e0;
   logic [31:0] c0;

   task automatic snap();
      w0 = nwr; d0 = ndone; e0 = nerr; c0 = rx_counter;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_state", 32'(rx_state), 32'd0);
      chk("rst_wr_en", 32'(ram_wr_en), 32'd0);
      chk("rst_counter", rx_counter, 32'd0);
      chk("rst_lengths", {rx_total_length, rx_data_length}, 32'd0);
      chk("rst_pulses", {30'd0, rx_done, rx_err}, 32'd0);
      rst = 1'b0;

      // 8-byte payload
      snap();
      build(GOOD, 16'h1F90, 8, 8'h01, 8'h01, 16'h0);
      send(-1, -1);
      chk("a_nwr", 32'(nwr - w0), 32'd2);
      chk("a_w0", {23'd0, wa[w0]}, 32'd1);
      chk("a_d0", wd[w0], 32'h01020304);
      chk("a_w1", {23'd0, wa[w0+1]}, 32'd2);
      chk("a_d1", wd[w0+1], 32'h05060708);
      chk("a_done", 32'(ndone - d0), 32'd1);
      chk("a_done_with_wr", 32'(done_alone), 32'd0);
      chk("a_err", 32'(nerr - e0), 32'd0);
      chk("a_dlen", 32'(rx_data_length), 32'd16);
      chk("a_tlen", 32'(rx_total_length), 32'd36);
      chk("a_counter", rx_counter, 32'd1);
      chk("a_idle", 32'(rx_state), 32'd0);

      // 5-byte payload: zero-padded tail word
      snap();
      build(GOOD, 16'h1F90, 5, 8'hAA, 8'h11, 16'h0);
      send(-1, -1);
      chk("b_nwr", 32'(nwr - w0), 32'd2);
      chk("b_d0", wd[w0], 32'hAABBCCDD);
      chk("b_w1", {23'd0, wa[w0+1]}, 32'd2);
      chk("b_d1", wd[w0+1], 32'hEE000000);
      chk("b_done", 32'(ndone - d0), 32'd1);
      chk("b_dlen", 32'(rx_data_length), 32'd13);
      chk("b_tlen", 32'(rx_total_length), 32'd33);
      chk("b_counter", rx_counter, 32'd2);

      // foreign MAC: silently ignored
      snap();
      build(48'h000D1157283F, 16'h1F90, 8, 8'h01, 8'h01, 16'h0);
      send(-1, -1);
      chk("mac_nwr", 32'(nwr - w0), 32'd0);
      chk("mac_done", 32'(ndone - d0), 32'd0);
      chk("mac_err", 32'(nerr - e0), 32'd0);
      chk("mac_counter", rx_counter, c0);

      // broadcast MAC, single-byte payload
      snap();
      build(48'hFFFFFFFFFFFF, 16'h1F90, 1, 8'h5A, 8'h00, 16'h0);
      send(-1, -1);
      chk("bc_nwr", 32'(nwr - w0), 32'd1);
      chk("bc_d0", wd[w0], 32'h5A000000);
      chk("bc_dlen", 32'(rx_data_length), 32'd9);
      chk("bc_counter", rx_counter, 32'd3);

      // rxdv falls after the 3rd payload byte
      snap();
      build(GOOD, 16'h1F90, 8, 8'h01, 8'h01, 16'h0);
      send(45, -1);
      chk("ab_err", 32'(nerr - e0), 32'd1);
      chk("ab_nwr", 32'(nwr - w0), 32'd0);
      chk("ab_done", 32'(ndone - d0), 32'd0);
      chk("ab_state", 32'(rx_state), 32'd0);
      chk("ab_dlen_held", 32'(rx_data_length), 32'd9);
      snap();
      send(-1, -1);
      chk("ab_next_d1", wd[w0+1], 32'h05060708);
      chk("ab_next_counter", rx_counter, 32'd4);

      // rxer inside the IP header
      snap();
      send(-1, 19);
      chk("er_err", 32'(nerr - e0), 32'd1);
      chk("er_nwr", 32'(nwr - w0), 32'd0);
      chk("er_counter", rx_counter, c0);
      chk("er_state", 32'(rx_state), 32'd0);

      // wrong UDP port, and UDP length 8 (empty payload): both dropped silently
      snap();
      build(GOOD, 16'h1F91, 4, 8'h01, 8'h01, 16'h0);
      send(-1, -1);
      build(GOOD, 16'h1F90, 0, 8'h01, 8'h01, 16'h0);
      send(-1, -1);
      chk("drop_nwr", 32'(nwr - w0), 32'd0);
      chk("drop_err", 32'(nerr - e0), 32'd0);
      chk("drop_counter", rx_counter, c0);

      // IP header checksum off by one
      snap();
      build(GOOD, 16'h1F90, 4, 8'h10, 8'h01, 16'h1);
      send(-1, -1);
`ifdef GMII_UDP_RX_CSUM_EN
      chk("cs_err", 32'(nerr - e0), 32'd1);
      chk("cs_nwr", 32'(nwr - w0), 32'd0);
      chk("cs_counter", rx_counter, c0);
`else
      chk("cs_err", 32'(nerr - e0), 32'd0);
      chk("cs_nwr", 32'(nwr - w0), 32'd1);
      chk("cs_counter", rx_counter, c0 + 32'd1);
`endif
      snap();
      build(GOOD, 16'h1F90, 4, 8'h10, 8'h01, 16'h0);
      send(-1, -1);
      chk("cs_ok_d0", wd[w0], 32'h10111213);
      chk("cs_ok_counter", rx_counter, c0 + 32'd1);

      // reset mid-payload discards the packet
      snap();
      repeat (7) drive(1'b1, 1'b0, 8'h55);
      drive(1'b1, 1'b0, 8'hD5);
      for (int i = 0; i < 44; i++) drive(1'b1, 1'b0, fr[i]);
      rst = 1'b1;
      drive(1'b1, 1'b0, fr[44]);
      #1;
      chk("rst_mid_state", 32'(rx_state), 32'd0);
      chk("rst_mid_counter", rx_counter, 32'd0);
      rst = 1'b0;
      repeat (4) drive(1'b0, 1'b0, 8'h00);
      chk("rst_mid_nwr", 32'(nwr - w0), 32'd0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule

// File: doc/gmii_udp_rx.md
Name: gmii_udp_rx

Overview:
- GMII-side receiver for the UDP/IPv4 frames produced by the team's UDP sender.
- Strips preamble/SFD, filters on destination MAC, EtherType, IP protocol, destination IP and UDP port.
- Packs the UDP payload big-endian into 32-bit words and writes them to a payload RAM.
- Reports lengths, a done pulse and an error pulse to the node controller.

Parameters:
- LOCAL_MAC, 48'h000A3501FEC0, accepted destination MAC; 48'hFFFFFFFFFFFF is always accepted as well.
- LOCAL_IP, 32'hC0A80002, accepted IPv4 destination address.
- LOCAL_PORT, 16'h1F90, accepted UDP destination port.
- RAM_BASE, 9'd1, first RAM word address written for each packet.

Ports:
- clk  in  1  GMII receive clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- rxdv  in  1  GMII receive data valid.
- rxer  in  1  GMII receive error.
- datain  in  8  GMII receive byte.
- ram_wr_en  out  1  payload RAM write strobe.
- ram_wr_addr  out  9  payload RAM word address.
- ram_wr_data  out  32  payload word; first byte in [31:24].
- rx_state  out  4  current FSM state, for debug.
- rx_total_length  out  16  IP total length of the last accepted packet.
- rx_data_length  out  16  UDP length field of the last accepted packet.
- rx_done  out  1  one-cycle pulse when the last payload word is written.
- rx_err  out  1  one-cycle pulse on an aborted or malformed packet.
- rx_counter  out  32  count of packets that completed with rx_done.

Behaviour:
- Reset: every output is 0; rx_state=IDLE; internal byte counters are 0.
- States:
  - IDLE=0: wait for rxdv=1 with datain=8'h55, then go to PREAMBLE.
  - PREAMBLE=1: stay while the byte is 55; byte D5 goes to MAC; any other byte goes to DROP.
  - MAC=2: 14 bytes. Bytes 0-5 are the destination MAC and must equal LOCAL_MAC or broadcast. Bytes 12-13 must be 08,00. On mismatch go to DROP at the end of byte 13.
  - IPHDR=3: 20 bytes.
    - Byte 0 must be 8'h45.
    - Bytes 2-3 are latched into rx_total_length (held internally; output register updated only at rx_done).
    - Byte 9 must be 8'h11.
    - Bytes 16-19 must equal LOCAL_IP.
    - On mismatch go to DROP after byte 19.
  - UDPHDR=4: 8 bytes. Bytes 2-3 must equal LOCAL_PORT. Bytes 4-5 are the UDP length L. L<9 goes to DROP (no empty payloads).
  - DATA=5: L-8 payload bytes, shifted in MSB-first.
    - On every 4th byte: ram_wr_en=1 for one cycle with the packed word; address starts at RAM_BASE and increments after each write.
    - Final partial word is zero-padded in its low bytes and written on the last payload byte.
    - Last write coincides with the rx_done pulse; at the same edge rx_data_length<=L, rx_total_length is updated and rx_counter increments. Then go to DROP to discard trailer/FCS.
  - DROP=6: ignore bytes until rxdv=0, then go to IDLE.
- Latency: the RAM write is registered, asserted the cycle after the 4th byte is sampled.
- ram_wr_addr is 9 bits and wraps 511→0 with no error.
- Abort:
  - rxdv falling in any state other than IDLE/DROP → rx_err pulse, go to IDLE. Words already written stay written; no rx_done.
  - rxer=1 while rxdv=1 in PREAMBLE..DATA → rx_err, go to DROP.
  - Header mismatches go to DROP silently, without rx_err.
- rxdv=1 continuously after DROP does not start a new frame; rxdv must drop first.
- rst has priority over all events, including mid-frame: FSM goes to IDLE and the partial packet is discarded.
- No FCS check; the FCS bytes are discarded in DROP.

Optional Feature:
- Macro: GMII_UDP_RX_CSUM_EN.
- When defined:
  - Accumulate the 10 IP header 16-bit words in a 32-bit sum and fold the carry twice.
  - Result must equal 16'hFFFF, otherwise rx_err pulses and the FSM goes to DROP after IP byte 19.
  - Payload writes never begin for a bad header.
- When undefined: the checksum field is ignored.

Test Plan:
- Valid frame, dst MAC 00-0A-35-01-FE-C0, UDP length 16, payload 01..08 → writes 32'h01020304@1 and 32'h05060708@2; rx_done pulses once with the second write; rx_data_length=16; rx_counter=1.
- Payload of 5 bytes (L=13), payload AA BB CC DD EE → writes 32'hAABBCCDD@1 and 32'hEE000000@2; rx_done pulses.
- Dst MAC 00-0D-11-57-28-3F → no ram_wr_en, no rx_done, no rx_err; next valid frame is accepted normally.
- rxdv dropped after the 3rd payload byte → rx_err pulse, no RAM write, FSM in IDLE; a following valid frame is accepted.
- rxer asserted in IPHDR → rx_err, DROP until rxdv=0; rx_counter unchanged.
- With GMII_UDP_RX_CSUM_EN: header checksum off by 1 → rx_err, no writes; correct checksum → accepted.
